// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and receiver.
// Contents: line levels and the transmit FSM state encoding.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_FETCH  = 3'd1,
    UART_ST_START  = 3'd2,
    UART_ST_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    UART_ST_PARITY = 3'd5,
`endif
    UART_ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts down from period-1 to 0 and flags the last
// cycle of every bit period.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   period_i      bit period in cycles (must be >= 1)
//   restart_i     reload the count from period_i at the next edge
//   bit_done_o    high during the last cycle of each bit period
module uart_bit_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] period_i,
  input  logic             restart_i,
  output logic             bit_done_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  // Reload on restart or at the end of a period, otherwise count down.
  always_comb begin
    count_d = count_q - WIDTH'(1);
    if (restart_i || done_q) begin
      count_d = period_i - WIDTH'(1);
    end
    done_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      done_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign bit_done_o = done_q;

endmodule

// File: rtl/uart_fifo_transmitter.sv
// UART transmitter draining a FIFO: fetches one word per frame with a
// single-cycle fifoOe pulse and sends it LSB-first as start/data/stop.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   enable          permits new frames (sampled in IDLE only)
//   cyclesPerBit    bit period in cycles, 0 treated as 1
//   fifoIsData      FIFO non-empty flag
//   fifoDataOut     FIFO head word
//   fifoOe          pop request, first START cycle only
//   tx              serial line, idle high
//   busy            high from FETCH through the last stop-bit cycle
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit.
module uart_fifo_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned WORD_SIZE         = 8,
  parameter int unsigned CLOCK_SCALE_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [CLOCK_SCALE_WIDTH-1:0] cyclesPerBit,
  input  logic                         fifoIsData,
  input  logic [WORD_SIZE-1:0]         fifoDataOut,
  output logic                         fifoOe,
  output logic                         tx,
  output logic                         busy
);

  localparam int unsigned IDX_W = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE - 1);

  uart_state_e                  state_q;
  logic [WORD_SIZE-1:0]         shift_q;
  logic [IDX_W-1:0]             bit_idx_q;
  logic [CLOCK_SCALE_WIDTH-1:0] period_q;
  logic                         tx_q, busy_q, oe_q;
`ifdef UART_TX_PARITY_EN
  logic                         parity_q;
`endif

  logic [CLOCK_SCALE_WIDTH-1:0] period_c, timer_period_c;
  logic                         restart_c, bit_done;

  // Zero period is mapped to one; the timer sees the fresh value while
  // it is being latched in FETCH and the frozen value during the frame.
  assign period_c       = (cyclesPerBit == '0) ? CLOCK_SCALE_WIDTH'(1) : cyclesPerBit;
  assign timer_period_c = (state_q == UART_ST_FETCH) ? period_c : period_q;
  assign restart_c      = (state_q == UART_ST_FETCH);

  uart_bit_timer #(
    .WIDTH(CLOCK_SCALE_WIDTH)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .period_i  (timer_period_c),
    .restart_i (restart_c),
    .bit_done_o(bit_done)
  );

  // Frame sequencer; line level and pop strobe are set one edge ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= UART_ST_IDLE;
      tx_q      <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
      oe_q      <= 1'b0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      period_q  <= CLOCK_SCALE_WIDTH'(1);
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      oe_q <= 1'b0;
      case (state_q)
        UART_ST_IDLE: begin
          tx_q <= UART_IDLE_LEVEL;
          if (enable && fifoIsData) begin
            state_q <= UART_ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        UART_ST_FETCH: begin
          shift_q   <= fifoDataOut;
          period_q  <= period_c;
          bit_idx_q <= '0;
          tx_q      <= UART_START_LEVEL;
          oe_q      <= 1'b1;
          state_q   <= UART_ST_START;
`ifdef UART_TX_PARITY_EN
          parity_q  <= ^fifoDataOut;
`endif
        end
        UART_ST_START: begin
          if (bit_done) begin
            state_q <= UART_ST_DATA;
            tx_q    <= shift_q[0];
          end
        end
        UART_ST_DATA: begin
          if (bit_done) begin
            if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
              state_q <= UART_ST_PARITY;
              tx_q    <= parity_q;
`else
              state_q <= UART_ST_STOP;
              tx_q    <= UART_STOP_LEVEL;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        UART_ST_PARITY: begin
          if (bit_done) begin
            state_q <= UART_ST_STOP;
            tx_q    <= UART_STOP_LEVEL;
          end
        end
`endif
        UART_ST_STOP: begin
          if (bit_done) begin
            state_q <= UART_ST_IDLE;
            busy_q  <= 1'b0;
            tx_q    <= UART_IDLE_LEVEL;
          end
        end
        default: begin
          state_q <= UART_ST_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

  assign fifoOe = oe_q;
  assign tx     = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_fifo_transmitter.sv
// Bench for uart_fifo_transmitter: behavioural FIFO and frame-level line
// model checked every cycle, plus hand-computed literal expectations.
module tb_uart_fifo_transmitter;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] cyclesPerBit = 16'd4;
  logic        fifoIsData = 1'b0;
  logic [7:0]  fifoDataOut = 8'h00;
  logic        fifoOe, tx, busy;

  int tests = 0;
  int fails = 0;
  int prints = 0;
  int cyc = 0;
  int base = 0;
  int oe_cnt = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  uart_fifo_transmitter #(.WORD_SIZE(8), .CLOCK_SCALE_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cyclesPerBit(cyclesPerBit),
    .fifoIsData  (fifoIsData),
    .fifoDataOut (fifoDataOut),
    .fifoOe      (fifoOe),
    .tx          (tx),
    .busy        (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (fifoOe) oe_cnt <= oe_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - base);
      end
    end
  endtask

  // Wait until the falling edge of relative cycle n.
  task automatic goto(input int n);
    while (!((cyc >= base + n) && (clk == 1'b0))) @(negedge clk);
  endtask

  // Registered FIFO: pop one edge after fifoOe, flags follow the queue.
  always @(posedge clk) begin
    if (fifoOe) begin
      if (q.size() == 0) chk("pop_while_empty", 1, 0);
      else q.delete(0);
    end
    fifoIsData  <= (q.size() != 0);
    fifoDataOut <= (q.size() != 0) ? q[0] : 8'h00;
  end

  // Frame-level model: IDLE, one FETCH cycle, then NB bits of L cycles each.
  typedef enum {M_IDLE, M_FETCH, M_FRAME} mst_e;
  mst_e       m_st = M_IDLE;
  logic [7:0] m_data = 8'h00;
  int         m_len = 1;
  int         m_off = 0;

  always @(negedge clk) begin : model_b
    int e_tx, e_busy, e_oe, b;
    e_tx = 1; e_busy = 0; e_oe = 0;
    if (rst) begin
      m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: if (enable && fifoIsData) m_st = M_FETCH;
        M_FETCH: begin
          e_busy = 1;
          m_data = fifoDataOut;
          m_len  = (cyclesPerBit == 16'd0) ? 1 : int'(cyclesPerBit);
          m_off  = 0;
          m_st   = M_FRAME;
        end
        default: begin
          b = m_off / m_len;
          e_busy = 1;
          e_oe = (m_off == 0) ? 1 : 0;
          if (b == 0) e_tx = 0;
          else if (b <= W) e_tx = int'(m_data[b-1]);
`ifdef UART_TX_PARITY_EN
          else if (b == W + 1) e_tx = int'(^m_data);
`endif
          else e_tx = 1;
          m_off++;
          if (m_off == NB * m_len) m_st = M_IDLE;
        end
      endcase
    end
    chk("model_tx", int'(tx), e_tx);
    chk("model_busy", int'(busy), e_busy);
    chk("model_fifoOe", int'(fifoOe), e_oe);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int hi, oe0, g;
    int a5_exp[11];
    int x5a_exp[8];
`ifdef UART_TX_PARITY_EN
    a5_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    a5_exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
`endif
    x5a_exp = '{0, 1, 0, 1, 1, 0, 1, 0};

    // Reset values, then an empty FIFO keeps the line idle.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_oe", int'(fifoOe), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx) hi++;
    end
    chk("idle_hold_100", hi, 100);

    // Single word 0xA5, L=4.
    @(posedge clk); #1;
    cyclesPerBit = 16'd4; oe0 = oe_cnt;
    q.push_back(8'hA5); base = cyc + 1;
    goto(1); chk("a5_fetch_tx", int'(tx), 1); chk("a5_fetch_busy", int'(busy), 1);
    goto(2); chk("a5_start_tx", int'(tx), 0); chk("a5_oe", int'(fifoOe), 1);
    goto(3); chk("a5_oe_single", int'(fifoOe), 0);
    for (int i = 0; i < NB; i++) begin
      goto(2 + 4 * i + 2);
      chk("a5_bit", int'(tx), a5_exp[i]);
    end
    goto(1 + 4 * NB); chk("a5_busy_last", int'(busy), 1);
    goto(2 + 4 * NB); chk("a5_busy_fall", int'(busy), 0);
    chk("a5_oe_count", oe_cnt - oe0, 1);

    // Three words back-to-back, L=3.
    @(posedge clk); #1;
    cyclesPerBit = 16'd3; oe0 = oe_cnt;
    q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55); base = cyc + 1;
    goto(2 + 3 * NB); chk("b2b_gap_idle_busy", int'(busy), 0); chk("b2b_gap_idle_tx", int'(tx), 1);
    goto(3 + 3 * NB); chk("b2b_gap_fetch_tx", int'(tx), 1);
    goto(4 + 3 * NB); chk("b2b_f2_start", int'(tx), 0); chk("b2b_f2_oe", int'(fifoOe), 1);
    g = 2 + 2 * (3 * NB + 2) + 3 * NB;
    goto(g); chk("b2b_end_busy", int'(busy), 0);
    goto(g + 5);
    chk("b2b_oe_count", oe_cnt - oe0, 3);
    chk("b2b_fifo_empty", q.size(), 0);
    chk("b2b_isdata_low", int'(fifoIsData), 0);

    // cyclesPerBit = 0 behaves as one cycle per bit; 0x3C.
    @(posedge clk); #1;
    cyclesPerBit = 16'd0;
    q.push_back(8'h3C); base = cyc + 1;
    goto(2); chk("cpb0_start", int'(tx), 0);
    goto(3); chk("cpb0_bit0", int'(tx), 0);
    goto(5); chk("cpb0_bit2", int'(tx), 1);
    goto(1 + NB); chk("cpb0_busy_last", int'(busy), 1);
    goto(2 + NB); chk("cpb0_busy_fall", int'(busy), 0);

    // Period change 8 -> 2 mid-frame; words 0x81 then 0x42.
    @(posedge clk); #1;
    cyclesPerBit = 16'd8;
    q.push_back(8'h81); q.push_back(8'h42); base = cyc + 1;
    goto(10);
    @(posedge clk); #1;
    cyclesPerBit = 16'd2;
    goto(17); chk("chg_bit0_held", int'(tx), 1);
    goto(18); chk("chg_bit1", int'(tx), 0);
    goto(1 + 8 * NB); chk("chg_f1_busy_last", int'(busy), 1);
    goto(2 + 8 * NB); chk("chg_f1_busy_fall", int'(busy), 0);
    goto(4 + 8 * NB); chk("chg_f2_start", int'(tx), 0);
    goto(6 + 8 * NB); chk("chg_f2_bit0", int'(tx), 0);
    goto(8 + 8 * NB); chk("chg_f2_bit1", int'(tx), 1);
    goto(3 + 10 * NB); chk("chg_f2_busy_last", int'(busy), 1);
    goto(4 + 10 * NB); chk("chg_f2_busy_fall", int'(busy), 0);

    // enable dropped during frame 1 with two words queued.
    @(posedge clk); #1;
    cyclesPerBit = 16'd2; oe0 = oe_cnt;
    q.push_back(8'h11); q.push_back(8'h22); base = cyc + 1;
    goto(8);
    @(posedge clk); #1;
    enable = 1'b0;
    goto(1 + 2 * NB); chk("en_f1_completes", int'(busy), 1);
    goto(12 + 2 * NB);
    chk("en_busy_low", int'(busy), 0);
    chk("en_oe_count", oe_cnt - oe0, 1);
    chk("en_fifo_left", q.size(), 1);
    @(posedge clk); #1;
    enable = 1'b1; base = cyc;
    goto(2); chk("en_resume_start", int'(tx), 0); chk("en_resume_oe", int'(fifoOe), 1);
    goto(2 + 2 * NB);
    chk("en_resume_done", int'(busy), 0);
    chk("en_resume_oe_count", oe_cnt - oe0, 2);

    // Reset pulsed during bit 4 of 0xC3; 0x5A must follow intact.
    @(posedge clk); #1;
    cyclesPerBit = 16'd2; oe0 = oe_cnt;
    q.push_back(8'hC3); q.push_back(8'h5A); base = cyc + 1;
    goto(11);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_tx", int'(tx), 1);
    chk("rst_mid_busy", int'(busy), 0);
    goto(13);
    @(posedge clk); #1;
    rst = 1'b0;
    goto(15);
    chk("rst_no_pop", oe_cnt - oe0, 1);
    chk("rst_fifo_left", q.size(), 1);
    goto(16); chk("rst_next_start", int'(tx), 0);
    for (int i = 0; i < 8; i++) begin
      goto(19 + 2 * i);
      chk("rst_next_bit", int'(tx), x5a_exp[i]);
    end
    goto(16 + 2 * NB);
    chk("rst_next_done", int'(busy), 0);
    chk("rst_oe_count", oe_cnt - oe0, 2);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0; frames of 11 bits.
    @(posedge clk); #1;
    cyclesPerBit = 16'd2;
    q.push_back(8'h07); q.push_back(8'h03); base = cyc + 1;
    goto(20); chk("par_07", int'(tx), 1);
    goto(23); chk("par_f1_busy_last", int'(busy), 1);
    goto(24); chk("par_f1_busy_fall", int'(busy), 0);
    goto(44); chk("par_03", int'(tx), 0);
    goto(48); chk("par_f2_busy_fall", int'(busy), 0);
`endif

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_fifo_transmitter.md
# uart_fifo_transmitter

Serial transmitter that drains the read side of a FIFO and emits 8N1-style asynchronous frames on a single line. It watches the FIFO's `isData` flag, fetches one word per frame with a single-cycle `oe` pulse, and shifts it out LSB-first at a programmable bit period. It is the consumer end of the UART transmit path: the CPU-facing register block writes the FIFO, and this block reads it.

## Interface
Parameters:
- `WORD_SIZE`, 8: data bits per frame; must match the FIFO word size.
- `CLOCK_SCALE_WIDTH`, 16: width of the bit-period count.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  allows new frames to start; sampled only in IDLE.
- `cyclesPerBit`  in  CLOCK_SCALE_WIDTH  clock cycles per serial bit; 0 treated as 1.
- `fifoIsData`  in  1  FIFO non-empty flag.
- `fifoDataOut`  in  WORD_SIZE  FIFO head word, registered by the FIFO.
- `fifoOe`  out  1  single-cycle pop request to the FIFO.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high from FETCH through the last stop-bit cycle.

## Operation
- Reset values: `tx`=1, `busy`=0, `fifoOe`=0, state IDLE, bit counter 0, shift register 0.
- States: IDLE, FETCH, START, DATA, PARITY (macro only), STOP.
- IDLE: `tx`=1. If `enable && fifoIsData`, go to FETCH.
- FETCH: lasts one cycle and allows `fifoDataOut` to settle on the head word. On exit, load the shift register from `fifoDataOut` and latch `cyclesPerBit`, with 0 mapped to 1. Go to START.
- START: `tx`=0. `fifoOe`=1 in the first START cycle only.
- DATA: `tx`=shift[0]. Shift right at each bit boundary. WORD_SIZE bits, LSB first.
- STOP: `tx`=1 for one bit period, then go to IDLE.
- Bit period: every bit is held exactly L cycles, where L is the latched period. A `cyclesPerBit` change mid-frame takes effect at the next FETCH.
- `enable` deasserted mid-frame: the current frame completes and no new fetch starts.
- `fifoIsData` falling mid-frame has no effect. The frame in flight always completes.
- `fifoOe` is never asserted outside START, so the FIFO can never be popped while empty.
- Reset mid-frame: `tx` returns to 1 immediately (asynchronous). The frame is abandoned and no pop is issued.

## Timing
- If `fifoIsData` is first seen high in IDLE at cycle 0, FETCH is cycle 1. `tx` falls and `fifoOe` pulses at cycle 2.
- Frame length is (WORD_SIZE+2)·L cycles, or (WORD_SIZE+3)·L with parity.
- Back-to-back frames are separated by exactly 2 extra `tx`=1 cycles (the IDLE and FETCH cycles).
- The FIFO pointer advances 1–2 cycles after `fifoOe`. The minimum frame of 10 cycles guarantees a fresh head word before the next FETCH.
- `busy` rises on entry to FETCH and falls on entry to IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP. `tx` = XOR of the WORD_SIZE data bits (even parity) for L cycles.
- `UART_TX_PARITY_EN` undefined: there is no PARITY state; DATA goes directly to STOP.

## Structure
- Shared package `uart_pkg`: state enum, `UART_IDLE_LEVEL`=1, `UART_START_LEVEL`=0, `UART_STOP_LEVEL`=1. The receiver reuses these.
- One sub-module, `uart_bit_timer`. It takes the latched period and a restart input. It asserts a one-cycle `bitDone` every L cycles and counts down from L-1 to 0.
- The top level holds the FSM, shift register, bit index and `fifoOe` register.

## Test plan
- Reset: with `rst` high, `tx`=1, `busy`=0 and `fifoOe`=0. Release with the FIFO empty; `tx` stays 1 for 100 cycles.
- Single word 0xA5 with `cyclesPerBit`=4: `tx` falls at cycle 2, exactly one `fifoOe` pulse, line reads 0,1,0,1,0,0,1,0,1,1 in 4-cycle bits, `busy` drops at cycle 42.
- Three words 0x00, 0xFF, 0x55 back-to-back with `cyclesPerBit`=3: exactly 3 `fifoOe` pulses, 2 idle cycles between frames, FIFO ends empty.
- `cyclesPerBit`=0: each bit lasts 1 cycle and the frame is 10 cycles. `cyclesPerBit` changed 8→2 mid-frame: the current frame keeps 8 and the next uses 2.
- `enable` dropped during the data bits of frame 1 with 2 words queued: frame 1 completes, no second `fifoOe`, `busy`=0 afterwards.
- `rst` pulsed during the bit-4 period: `tx`=1 in the same cycle, no further `fifoOe`. After release the queued word is sent intact.
- With `UART_TX_PARITY_EN` defined, 0x07 sends parity bit 1 and 0x03 sends parity bit 0; each frame is 11·L cycles.
